// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - three-requester (L/D/F) arbiter for a single-port byte RAM with lock bursts
// Optional: define RAM_ARB_RR_EN for round-robin between D and F in IDLE (L stays highest).
module ram_port_arbiter #(
    parameter int RAMSIZE = 64,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l_req,
    input  logic              l_lock,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [7:0]        l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [7:0]        l_rdata,
    output logic              l_err,
    input  logic              d_req,
    input  logic              d_lock,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [7:0]        d_rdata,
    output logic              d_err,
    input  logic              f_req,
    input  logic              f_lock,
    input  logic              f_we,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [7:0]        f_wdata,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [7:0]        f_rdata,
    output logic              f_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);
    localparam logic [1:0] ID_L = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
    localparam logic [1:0] ID_F = 2'd2;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_owner, w_owner_nxt;
    logic [2:0]        w_req, w_lock, w_gnt;
    logic              w_acc;
    logic [1:0]        w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [7:0]        w_sel_wdata;
    logic              w_in_range;
    logic              w_pick_f;

    logic              r_ram_en, r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_wdata;
    logic              r_s1_rd, r_s1_oor, r_s2_rd, r_s2_oor;
    logic [1:0]        r_s1_who, r_s2_who;
    logic [2:0]        r_err;
    logic [7:0]        r_l_rdata, r_d_rdata, r_f_rdata;
    logic [2:0]        w_rvalid;
    logic [7:0]        w_ret_data;

    assign w_req  = {f_req, d_req, l_req};
    assign w_lock = {f_lock, d_lock, l_lock};

`ifdef RAM_ARB_RR_EN
    logic r_rr_f;
    assign w_pick_f = r_rr_f;

    // Pointer only moves on D/F wins decided in IDLE; locked bursts leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_f <= 1'b0;
        end else if (r_state == ST_IDLE && w_acc && w_sel != ID_L) begin
            r_rr_f <= (w_sel == ID_D);
        end
    end
`else
    assign w_pick_f = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= ID_L;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_gnt       = 3'b000;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        if (!reset) begin
            if (r_state == ST_LOCKED) begin
                w_gnt[r_owner] = w_req[r_owner];
            end else if (w_req[ID_L]) begin
                w_gnt[ID_L] = 1'b1;
            end else if (w_req[ID_D] && w_req[ID_F]) begin
                w_gnt[ID_F] = w_pick_f;
                w_gnt[ID_D] = !w_pick_f;
            end else if (w_req[ID_D]) begin
                w_gnt[ID_D] = 1'b1;
            end else if (w_req[ID_F]) begin
                w_gnt[ID_F] = 1'b1;
            end
        end
        w_acc = |w_gnt;
        w_sel = w_gnt[ID_D] ? ID_D : (w_gnt[ID_F] ? ID_F : ID_L);
        if (w_acc) begin
            w_state_nxt = w_lock[w_sel] ? ST_LOCKED : ST_IDLE;
            w_owner_nxt = w_sel;
        end else if (r_state == ST_LOCKED && !w_req[r_owner] && !w_lock[r_owner]) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_sel_we    = l_we;
        w_sel_addr  = l_addr;
        w_sel_wdata = l_wdata;
        if (w_sel == ID_D) begin
            w_sel_we    = d_we;
            w_sel_addr  = d_addr;
            w_sel_wdata = d_wdata;
        end else if (w_sel == ID_F) begin
            w_sel_we    = f_we;
            w_sel_addr  = f_addr;
            w_sel_wdata = f_wdata;
        end
    end

    assign w_in_range = w_sel_addr < ADDR_W'(RAMSIZE);

    // Read returns follow a 2-stage owner tag so routing never depends on the current grant.
    assign w_rvalid   = r_s2_rd ? (3'b001 << r_s2_who) : 3'b000;
    assign w_ret_data = r_s2_oor ? 8'h00 : ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 8'h00;
            r_s1_rd     <= 1'b0;
            r_s1_oor    <= 1'b0;
            r_s1_who    <= ID_L;
            r_s2_rd     <= 1'b0;
            r_s2_oor    <= 1'b0;
            r_s2_who    <= ID_L;
            r_err       <= 3'b000;
            r_l_rdata   <= 8'h00;
            r_d_rdata   <= 8'h00;
            r_f_rdata   <= 8'h00;
        end else begin
            r_ram_en <= w_acc && w_in_range;
            r_ram_we <= w_acc && w_in_range && w_sel_we;
            if (w_acc) begin
                r_ram_addr  <= w_sel_addr;
                r_ram_wdata <= w_sel_wdata;
            end
            r_s1_rd  <= w_acc && !w_sel_we;
            r_s1_oor <= !w_in_range;
            r_s1_who <= w_sel;
            r_err    <= (w_acc && !w_in_range) ? w_gnt : 3'b000;
            r_s2_rd  <= r_s1_rd;
            r_s2_oor <= r_s1_oor;
            r_s2_who <= r_s1_who;
            if (w_rvalid[0]) r_l_rdata <= w_ret_data;
            if (w_rvalid[1]) r_d_rdata <= w_ret_data;
            if (w_rvalid[2]) r_f_rdata <= w_ret_data;
        end
    end

    assign l_gnt     = w_gnt[0];
    assign d_gnt     = w_gnt[1];
    assign f_gnt     = w_gnt[2];
    assign l_rvalid  = w_rvalid[0];
    assign d_rvalid  = w_rvalid[1];
    assign f_rvalid  = w_rvalid[2];
    assign l_rdata   = w_rvalid[0] ? w_ret_data : r_l_rdata;
    assign d_rdata   = w_rvalid[1] ? w_ret_data : r_d_rdata;
    assign f_rdata   = w_rvalid[2] ? w_ret_data : r_f_rdata;
    assign l_err     = r_err[0];
    assign d_err     = r_err[1];
    assign f_err     = r_err[2];
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
endmodule
